// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply sequencer:
//   - state_e          : sequencer state encoding
//   - PIPE_LAT_MIN/MAX : legal range of the PE-array result latency
//   - DRAIN_W          : width of a counter that spans the largest drain
//   - calc_max_dim / calc_idx_w / calc_slot_w : derived size helpers
//   - dim_in_range     : bounds check of a "dimension minus 1" field
// ---------------------------------------------------------------------------
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD_C,
    COMPUTE,
    DRAIN,
    WRITE_C,
    DONE
  } state_e;

  localparam int PIPE_LAT_MIN = 1;
  localparam int PIPE_LAT_MAX = 7;
  localparam int DRAIN_W      = $clog2(PIPE_LAT_MAX + 1);

  // Number of elements that fit side by side on the bus.
  function automatic int calc_max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  // Index width, never narrower than one bit.
  function automatic int calc_idx_w(input int max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

  // Scratchpad slot-select width, never narrower than one bit.
  function automatic int calc_slot_w(input int n_targets);
    return (n_targets > 1) ? $clog2(n_targets) : 1;
  endfunction

  // A dimension field holds (size - 1); it is legal when below MAX_DIM.
  function automatic logic dim_in_range(input logic [1:0] dim_m1, input int max_dim);
    return int'(dim_m1) < max_dim;
  endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// ---------------------------------------------------------------------------
// matmul_idx_counter
// Loadable up-counter with enable and terminal-count flag. Load has priority
// over enable. tc_o is high while count_o equals last_i.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (count -> 0)
//   load_i, load_val_i synchronous load
//   en_i               increment by one
//   last_i             terminal value
//   count_o, tc_o      current count, count_o == last_i
// ---------------------------------------------------------------------------
module matmul_idx_counter #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // flop samples the values from before the edge, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= load_val_i;
    end else if (en_i) begin
      count_o <= count_o + W'(1);
    end
  end

  assign tc_o = (count_o == last_i);

endmodule

// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
// Steps a PE array through C = A*B (+ old C in bias mode): optional bias-row
// load from the scratchpad, K+1 operand beats, a PIPE_LAT drain, N+1 result
// row writes, then a one-cycle done/start-clear strobe.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_bit_i              level start from the control register
//   mode_bit_i               1 = accumulate onto old C (bias rows loaded first)
//   write_target_i           scratchpad slot holding C
//   N_i, K_i, M_i            dimensions minus one
//   sp_busy_i                bus owns the scratchpad; stalls row transfers
//   address_a_o/address_b_o  column of A / row of B for the current beat
//   address_c_o              {slot, row} of the scratchpad row transfer
//   pe_valid_o               operand vectors valid
//   pe_clear_o               clear accumulators (first cycle of a run)
//   bias_load_o, sp_write_o  bias-row load / result-row write strobes
//   busy_o, done_o, err_o    status; err_o is sticky until the next start
//   start_clear_o            clears the start bit in the control register
//
// Timing: every output is a flop. At each edge the current state's handler
// produces the outputs for the following cycle, so a row/beat issued by a
// state appears one cycle after the state is entered. CHECK issues the first
// operand beat (or first bias row) itself, so the dimension check costs only
// one cycle on the normal path.
// ---------------------------------------------------------------------------
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int BUS_WIDTH   = 64,
  parameter  int PIPE_LAT    = 2,
  parameter  int SP_NTARGETS = 2,
  localparam int MAX_DIM     = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int IDX_W       = calc_idx_w(MAX_DIM),
  localparam int SLOT_W      = calc_slot_w(SP_NTARGETS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_bit_i,
  input  logic                    mode_bit_i,
  input  logic [SLOT_W-1:0]       write_target_i,
  input  logic [1:0]              N_i,
  input  logic [1:0]              K_i,
  input  logic [1:0]              M_i,
  input  logic                    sp_busy_i,
  output logic [IDX_W-1:0]        address_a_o,
  output logic [IDX_W-1:0]        address_b_o,
  output logic [SLOT_W+IDX_W-1:0] address_c_o,
  output logic                    pe_valid_o,
  output logic                    pe_clear_o,
  output logic                    bias_load_o,
  output logic                    sp_write_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    start_clear_o
);

  state_e              state_q;
  logic [IDX_W-1:0]    n_q;
  logic [IDX_W-1:0]    k_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [DRAIN_W-1:0]  drain_q;

  logic                dims_ok;
  logic                row_load, row_en, row_tc;
  logic                k_load, k_en, k_tc;
  logic [IDX_W-1:0]    row_cnt, k_cnt;

  assign dims_ok = dim_in_range(N_i, MAX_DIM) && dim_in_range(K_i, MAX_DIM) &&
                   dim_in_range(M_i, MAX_DIM);

  // Counter control. Both counters are zeroed at start; CHECK advances the one
  // whose first beat it issues, unless that beat is also the last.
  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch.
  always_comb begin
    row_load = 1'b0;
    row_en   = 1'b0;
    k_load   = 1'b0;
    k_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        row_load = start_bit_i;
        k_load   = start_bit_i;
      end
      CHECK: begin
        if (dims_ok) begin
          if (mode_bit_i) row_en = !sp_busy_i && (N_i != 2'd0);
          else            k_en   = (K_i != 2'd0);
        end
      end
      LOAD_C, WRITE_C: begin
        if (!sp_busy_i) begin
          row_load = row_tc;
          row_en   = !row_tc;
        end
      end
      COMPUTE: begin
        k_load = k_tc;
        k_en   = !k_tc;
      end
      default: ;
    endcase
  end

  matmul_idx_counter #(.W(IDX_W)) u_row_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (row_load),
    .load_val_i ('0),
    .en_i       (row_en),
    .last_i     (n_q),
    .count_o    (row_cnt),
    .tc_o       (row_tc)
  );

  matmul_idx_counter #(.W(IDX_W)) u_k_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (k_load),
    .load_val_i ('0),
    .en_i       (k_en),
    .last_i     (k_q),
    .count_o    (k_cnt),
    .tc_o       (k_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      n_q           <= '0;
      k_q           <= '0;
      slot_q        <= '0;
      drain_q       <= '0;
      address_a_o   <= '0;
      address_b_o   <= '0;
      address_c_o   <= '0;
      pe_valid_o    <= 1'b0;
      pe_clear_o    <= 1'b0;
      bias_load_o   <= 1'b0;
      sp_write_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      start_clear_o <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; only the issuing state raises them.
      pe_valid_o    <= 1'b0;
      pe_clear_o    <= 1'b0;
      bias_load_o   <= 1'b0;
      sp_write_o    <= 1'b0;
      done_o        <= 1'b0;
      start_clear_o <= 1'b0;
      busy_o        <= 1'b1;

      unique case (state_q)
        IDLE: begin
          busy_o <= start_bit_i;
          if (start_bit_i) begin
            pe_clear_o <= 1'b1;
            err_o      <= 1'b0;
            state_q    <= CHECK;
          end
        end

        CHECK: begin
          if (!dims_ok) begin
            err_o   <= 1'b1;
            state_q <= DONE;
          end else begin
            n_q    <= IDX_W'(N_i);
            k_q    <= IDX_W'(K_i);
            slot_q <= write_target_i;
            if (mode_bit_i) begin
              // First bias row goes out now unless the bus owns the scratchpad.
              address_c_o <= {write_target_i, {IDX_W{1'b0}}};
              if (sp_busy_i) begin
                state_q <= LOAD_C;
              end else begin
                bias_load_o <= 1'b1;
                state_q     <= (N_i == 2'd0) ? COMPUTE : LOAD_C;
              end
            end else begin
              pe_valid_o  <= 1'b1;
              address_a_o <= '0;
              address_b_o <= '0;
              state_q     <= (K_i == 2'd0) ? DRAIN : COMPUTE;
            end
          end
        end

        LOAD_C: begin
          // During a stall the pending row stays on the address.
          address_c_o <= {slot_q, row_cnt};
          if (!sp_busy_i) begin
            bias_load_o <= 1'b1;
            if (row_tc) state_q <= COMPUTE;
          end
        end

        COMPUTE: begin
          pe_valid_o  <= 1'b1;
          address_a_o <= k_cnt;
          address_b_o <= k_cnt;
          if (k_tc) state_q <= DRAIN;
        end

        DRAIN: begin
          if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
            drain_q <= '0;
            state_q <= WRITE_C;
          end else begin
            drain_q <= drain_q + DRAIN_W'(1);
          end
        end

        WRITE_C: begin
          address_c_o <= {slot_q, row_cnt};
          if (!sp_busy_i) begin
            sp_write_o <= 1'b1;
            if (row_tc) state_q <= DONE;
          end
        end

        DONE: begin
          done_o        <= 1'b1;
          start_clear_o <= 1'b1;
          state_q       <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
